// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - CPU bus responder for WRAM, HRAM and the IF/IE registers.
// Defining BUS_RESPONDER_ECHO_RAM_EN makes E000-FDFF alias WRAM; otherwise it is unmapped.
module bus_responder #(
    parameter int         WRAM_AW  = 13,
    parameter logic [7:0] OPEN_BUS = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr_bus,
    input  logic [7:0]  data_in,
    input  logic        rd,
    input  logic        wr,
    input  logic [4:0]  int_req,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        busy,
    output logic [4:0]  ie_out,
    output logic [4:0]  if_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_data_out;
    logic        r_data_valid;
    logic [4:0]  r_ie;
    logic [4:0]  r_if;

    logic [7:0] r_wram [0:(1<<WRAM_AW)-1];
    logic [7:0] r_hram [0:126];

    logic               w_accept;
    logic               w_sel_wram;
    logic               w_sel_hram;
    logic               w_sel_if;
    logic               w_sel_ie;
    logic [WRAM_AW-1:0] w_wram_idx;
    logic [6:0]         w_hram_idx;
    logic [7:0]         w_rdata;
    logic               w_commit;

    assign w_accept = rd ^ wr;
    assign w_commit = (r_state == S_WRITE);

    // Decode runs on the latched address so READ/WRITE see a stable target.
    always_comb begin
        w_sel_wram = (r_addr >= 16'hC000) && (r_addr <= 16'hDFFF);
        w_wram_idx = WRAM_AW'(r_addr);
`ifdef BUS_RESPONDER_ECHO_RAM_EN
        if ((r_addr >= 16'hE000) && (r_addr <= 16'hFDFF)) begin
            w_sel_wram = 1'b1;
            w_wram_idx = WRAM_AW'(r_addr - 16'h2000);
        end
`endif
        w_sel_hram = (r_addr >= 16'hFF80) && (r_addr <= 16'hFFFE);
        w_hram_idx = r_addr[6:0];
        w_sel_if   = (r_addr == 16'hFF0F);
        w_sel_ie   = (r_addr == 16'hFFFF);
    end

    always_comb begin
        w_rdata = OPEN_BUS;
        if (w_sel_wram) begin
            w_rdata = r_wram[w_wram_idx];
        end else if (w_sel_hram) begin
            w_rdata = r_hram[w_hram_idx];
        end else if (w_sel_if) begin
            w_rdata = {3'b111, r_if};
        end else if (w_sel_ie) begin
            w_rdata = {3'b000, r_ie};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = rd ? S_READ : S_WRITE;
                end
            end
            S_READ:  w_next_state = S_DONE;
            S_WRITE: w_next_state = S_DONE;
            S_DONE: begin
                if (!rd && !wr) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != S_IDLE);
        data_valid = r_data_valid;
        data_out   = r_data_out;
        ie_out     = r_ie;
        if_out     = r_if;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= 16'h0000;
            r_wdata      <= 8'h00;
            r_data_out   <= OPEN_BUS;
            r_data_valid <= 1'b0;
            r_ie         <= 5'd0;
            r_if         <= 5'd0;
        end else begin
            if ((r_state == S_IDLE) && w_accept) begin
                r_addr  <= addr_bus;
                r_wdata <= data_in;
            end
            if (r_state == S_READ) begin
                r_data_out <= w_rdata;
            end
            r_data_valid <= (r_state == S_READ);
            if (w_commit && w_sel_ie) begin
                r_ie <= r_wdata[4:0];
            end
            // Hardware requests OR in after the CPU value so a same-edge set always wins.
            r_if <= ((w_commit && w_sel_if) ? r_wdata[4:0] : r_if) | int_req;
        end
    end

    // RAM arrays carry no reset; the rst gate keeps an aborted access from landing.
    always_ff @(posedge clk) begin
        if (!rst && w_commit) begin
            if (w_sel_wram) begin
                r_wram[w_wram_idx] <= r_wdata;
            end
            if (w_sel_hram) begin
                r_hram[w_hram_idx] <= r_wdata;
            end
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - self-checking bench for bus_responder with a byte-map reference model.
module tb_bus_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr_bus = 16'h0000;
    logic [7:0]  data_in = 8'h00;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [4:0]  int_req = 5'd0;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        busy;
    logic [4:0]  ie_out;
    logic [4:0]  if_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] m_mem [int];
    logic [4:0] m_ie = 5'd0;
    logic [4:0] m_if = 5'd0;

    bus_responder dut (
        .clk        (clk),
        .rst        (rst),
        .addr_bus   (addr_bus),
        .data_in    (data_in),
        .rd         (rd),
        .wr         (wr),
        .int_req    (int_req),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .ie_out     (ie_out),
        .if_out     (if_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Storage key of a RAM-backed address, or -1 when the address is not RAM.
    function automatic int ram_key(input logic [15:0] a);
        int v;
        v = int'(a);
        if (v >= 'hC000 && v <= 'hDFFF) return v;
`ifdef BUS_RESPONDER_ECHO_RAM_EN
        if (v >= 'hE000 && v <= 'hFDFF) return v - 'h2000;
`endif
        if (v >= 'hFF80 && v <= 'hFFFE) return v;
        return -1;
    endfunction

    function automatic logic [7:0] model_read(input logic [15:0] a);
        int k;
        k = ram_key(a);
        if (k >= 0) return m_mem[k];
        if (a == 16'hFF0F) return {3'b111, m_if};
        if (a == 16'hFFFF) return {3'b000, m_ie};
        return 8'hFF;
    endfunction

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input logic [4:0] irq);
        int k;
        @(negedge clk);
        addr_bus = a; data_in = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0; int_req = irq;
        chk("wr_busy_write", 16'(busy), 16'd1);
        @(negedge clk);
        int_req = 5'd0;
        k = ram_key(a);
        if (k >= 0) m_mem[k] = d;
        if (a == 16'hFFFF) m_ie = d[4:0];
        m_if = ((a == 16'hFF0F) ? d[4:0] : m_if) | irq;
        chk("wr_busy_done", 16'(busy), 16'd1);
        chk("wr_if", 16'(if_out), 16'(m_if));
        chk("wr_ie", 16'(ie_out), 16'(m_ie));
        @(negedge clk);
        chk("wr_idle", 16'(busy), 16'd0);
    endtask

    task automatic do_read(input logic [15:0] a);
        @(negedge clk);
        addr_bus = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        chk("rd_busy_read", 16'(busy), 16'd1);
        chk("rd_dv_early", 16'(data_valid), 16'd0);
        @(negedge clk);
        chk("rd_busy_done", 16'(busy), 16'd1);
        chk("rd_dv", 16'(data_valid), 16'd1);
        chk("rd_data", 16'(data_out), 16'(model_read(a)));
        @(negedge clk);
        chk("rd_dv_low", 16'(data_valid), 16'd0);
        chk("rd_idle", 16'(busy), 16'd0);
    endtask

    initial begin
        int pulses;
        int kind;
        logic [15:0] a;
        logic [7:0]  d;
        logic [4:0]  irq;

        @(negedge clk);
        chk("rst_data_out", 16'(data_out), 16'hFF);
        chk("rst_dv", 16'(data_valid), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_ie", 16'(ie_out), 16'd0);
        chk("rst_if", 16'(if_out), 16'd0);
        rst = 1'b0;

        do_write(16'hC123, 8'h5A, 5'd0);
        do_read(16'hC123);

        do_write(16'hC010, 8'h3C, 5'd0);
        do_read(16'hE010);
        do_write(16'hE010, 8'h77, 5'd0);
        do_read(16'hC010);

        do_write(16'hFF80, 8'hA5, 5'd0);
        @(negedge clk);
        addr_bus = 16'hFF80; rd = 1'b1; pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (data_valid) pulses++;
        end
        rd = 1'b0;
        @(negedge clk);
        if (data_valid) pulses++;
        chk("held_pulses", 16'(pulses), 16'd1);
        chk("held_data", 16'(data_out), 16'hA5);

        addr_bus = 16'hC123; data_in = 8'h99; rd = 1'b1; wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("both_busy", 16'(busy), 16'd0);
        end
        rd = 1'b0; wr = 1'b0;
        do_read(16'hC123);

        do_write(16'hFF0F, 8'h00, 5'b00100);
        do_read(16'hFF0F);
        chk("if_e4", 16'(data_out), 16'hE4);
        do_write(16'hFFFF, 8'h1F, 5'd0);
        do_read(16'hFFFF);
        chk("ie_1f", 16'(data_out), 16'h1F);

        do_write(16'hFF90, 8'h11, 5'd0);
        do_read(16'hFF0F);
        @(negedge clk);
        addr_bus = 16'hFF90; data_in = 8'h22; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_data_out", 16'(data_out), 16'hFF);
        chk("arst_ie", 16'(ie_out), 16'd0);
        chk("arst_if", 16'(if_out), 16'd0);
        chk("arst_busy", 16'(busy), 16'd0);
        m_ie = 5'd0; m_if = 5'd0;
        @(negedge clk);
        rst = 1'b0;
        do_read(16'hFF90);
        do_read(16'h8000);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 4);
            d = 8'($urandom);
            irq = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            case (kind)
                0: a = 16'($urandom_range('hC000, 'hDFFF));
                1: a = 16'($urandom_range('hE000, 'hFDFF));
                2: a = 16'($urandom_range('hFF80, 'hFFFE));
                3: a = $urandom_range(0, 1) ? 16'hFF0F : 16'hFFFF;
                default: a = 16'($urandom_range('h8000, 'hBFFF));
            endcase
            if ($urandom_range(0, 1) == 0 || (ram_key(a) >= 0 && !m_mem.exists(ram_key(a))))
                do_write(a, d, irq);
            else
                do_read(a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
